// File: rtl/pim_dma_ctrl.sv
// ---------------------------------------------------------------------------
// pim_dma_ctrl
//   Word-copy engine kicked off by a PIM-opcode instruction. It reads LEN words
//   from data memory, one at a time, and writes each word to the PIM buffer
//   port. While a copy runs, busy_o stalls the core and hands the DMEM port to
//   this block.
//
// Ports
//   clk_i, rst_ni            clock, async active-low reset
//   dma_en_i                 start strobe, only honoured in IDLE
//   src_addr_i, dst_addr_i   source/destination byte addresses, sampled on start
//   len_i                    transfer length in words, sampled on start
//   busy_o, done_o           in-progress flag, one-cycle completion pulse
//   dmem_req_o/addr_o/gnt_i  DMEM read request channel
//   dmem_rvalid_i/rdata_i    DMEM read response channel
//   pim_valid_o/addr_o/data_o/ready_i  PIM write channel
// ---------------------------------------------------------------------------
module pim_dma_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              dma_en_i,
   input  logic [ADDR_W-1:0] src_addr_i,
   input  logic [ADDR_W-1:0] dst_addr_i,
   input  logic [LEN_W-1:0]  len_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              dmem_req_o,
   output logic [ADDR_W-1:0] dmem_addr_o,
   input  logic              dmem_gnt_i,
   input  logic              dmem_rvalid_i,
   input  logic [DATA_W-1:0] dmem_rdata_i,
   output logic              pim_valid_o,
   output logic [ADDR_W-1:0] pim_addr_o,
   output logic [DATA_W-1:0] pim_data_o,
   input  logic              pim_ready_i
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      WR      = 3'd3,
      DONE    = 3'd4
   } state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] src_q;
   logic [ADDR_W-1:0] dst_q;
   logic [LEN_W-1:0]  rem_q;
   logic [DATA_W-1:0] data_q;
   logic              busy_q;
   logic              done_q;
   logic              req_q;
   logic              pim_valid_q;

   // All control outputs are registered and change together with the state,
   // so each output is a pure function of the state the FSM has entered.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         src_q       <= '0;
         dst_q       <= '0;
         rem_q       <= '0;
         data_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         req_q       <= 1'b0;
         pim_valid_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (dma_en_i) begin
                  // Word-align both addresses; the low bits of the operands are dropped.
                  src_q  <= {src_addr_i[ADDR_W-1:2], 2'b00};
                  dst_q  <= {dst_addr_i[ADDR_W-1:2], 2'b00};
                  rem_q  <= len_i;
                  busy_q <= 1'b1;
                  if (len_i != '0) begin
                     state_q <= RD_REQ;
                     req_q   <= 1'b1;
                  end else begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            RD_REQ: begin
               if (dmem_gnt_i) begin
                  req_q   <= 1'b0;
                  state_q <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (dmem_rvalid_i) begin
                  data_q      <= dmem_rdata_i;
                  pim_valid_q <= 1'b1;
                  state_q     <= WR;
               end
            end
            WR: begin
               if (pim_ready_i) begin
                  pim_valid_q <= 1'b0;
                  // Modulo-2^ADDR_W increment; wrap-around is intentional.
                  src_q       <= src_q + ADDR_W'(4);
                  dst_q       <= dst_q + ADDR_W'(4);
                  rem_q       <= rem_q - LEN_W'(1);
                  if (rem_q == LEN_W'(1)) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= RD_REQ;
                     req_q   <= 1'b1;
                  end
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q     <= IDLE;
               busy_q      <= 1'b0;
               req_q       <= 1'b0;
               pim_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign dmem_req_o  = req_q;
   assign dmem_addr_o = src_q;
   assign pim_valid_o = pim_valid_q;
   assign pim_addr_o  = dst_q;
   assign pim_data_o  = data_q;

endmodule

// File: tb/tb_pim_dma_ctrl.sv
module tb_pim_dma_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dma_en = 1'b0;
   logic [31:0] src = '0, dst = '0;
   logic [15:0] len = '0;
   logic        busy, done, req, valid;
   logic [31:0] daddr, paddr, pdata;
   logic        gnt = 1'b0, rvalid = 1'b0, ready = 1'b0;
   logic [31:0] rdata = '0;

   always #5 clk = ~clk;

   pim_dma_ctrl #(.ADDR_W(32), .DATA_W(32), .LEN_W(16)) dut (
      .clk_i(clk), .rst_ni(rst_n), .dma_en_i(dma_en),
      .src_addr_i(src), .dst_addr_i(dst), .len_i(len),
      .busy_o(busy), .done_o(done),
      .dmem_req_o(req), .dmem_addr_o(daddr), .dmem_gnt_i(gnt),
      .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
      .pim_valid_o(valid), .pim_addr_o(paddr), .pim_data_o(pdata),
      .pim_ready_i(ready)
   );

   typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
   wr_t exp_wr[$];
   int  exp_done[$];

   int errs = 0, nchk = 0;
   int cyc = 0, start_cyc = 0;
   int done_cnt = 0, busy_cnt = 0, req_cnt = 0, val_cnt = 0;
   int gnt_dly = 0, rv_dly = 1, rdy_dly = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      nchk++;
      errs++;
      $display("FAIL %s: got event, expected none", name);
   endtask

   // DMEM contents: a fixed pattern with one marked word at 0x100.
   function automatic logic [31:0] mem(input logic [31:0] a);
      if (a == 32'h100) return 32'hDEADBEEF;
      return {a[15:0], ~a[15:0]};
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // DMEM / PIM responders with programmable wait states.
   initial begin
      int req_held = 0, val_held = 0, rv_cnt = 0;
      logic [31:0] rv_addr = '0;
      forever begin
         @(posedge clk); #1;
         if (!rst_n) begin
            req_held = 0; val_held = 0; rv_cnt = 0;
            gnt = 1'b0; rvalid = 1'b0; ready = 1'b0;
         end else begin
            rvalid = 1'b0;
            if (rv_cnt > 0) begin
               rv_cnt--;
               if (rv_cnt == 0) begin
                  rvalid = 1'b1;
                  rdata  = mem(rv_addr);
               end
            end
            gnt = 1'b0;
            if (req) begin
               if (req_held >= gnt_dly) begin
                  gnt = 1'b1; rv_cnt = rv_dly; rv_addr = daddr; req_held = 0;
               end else req_held++;
            end
            ready = 1'b0;
            if (valid) begin
               if (val_held >= rdy_dly) begin
                  ready = 1'b1; val_held = 0;
               end else val_held++;
            end
         end
      end
   end

   // Monitor / scoreboard.
   initial begin
      logic p_req = 1'b0, p_gnt = 1'b0, p_val = 1'b0, p_rdy = 1'b0;
      logic [31:0] p_daddr = '0, p_paddr = '0, p_pdata = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            p_req = 1'b0; p_val = 1'b0; busy_cnt = 0;
         end else begin
            if (busy)  busy_cnt++;
            if (req)   req_cnt++;
            if (valid) val_cnt++;
            if (p_req && !p_gnt) begin
               chk("req_hold", 64'(req), 64'(1));
               chk("req_addr_hold", 64'(daddr), 64'(p_daddr));
            end
            if (p_val && !p_rdy) begin
               chk("valid_hold", 64'(valid), 64'(1));
               chk("pim_addr_hold", 64'(paddr), 64'(p_paddr));
               chk("pim_data_hold", 64'(pdata), 64'(p_pdata));
            end
            if (valid && ready) begin
               if (exp_wr.size() == 0) fail("pim_write_unexpected");
               else begin
                  wr_t e;
                  e = exp_wr.pop_front();
                  chk("pim_addr", 64'(paddr), 64'(e.a));
                  chk("pim_data", 64'(pdata), 64'(e.d));
               end
            end
            if (done) begin
               if (exp_done.size() == 0) fail("done_unexpected");
               else begin
                  int e;
                  e = exp_done.pop_front();
                  chk("done_cycle", 64'(cyc - start_cyc + 1), 64'(e));
                  chk("busy_cycles", 64'(busy_cnt), 64'(e));
               end
               busy_cnt = 0;
               done_cnt++;
            end
            p_req = req; p_gnt = gnt; p_daddr = daddr;
            p_val = valid; p_rdy = ready; p_paddr = paddr; p_pdata = pdata;
         end
      end
   end

   task automatic start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
      @(posedge clk); #1;
      dma_en = 1'b1; src = s; dst = d; len = l;
      @(posedge clk); #1;
      start_cyc = cyc;
      dma_en = 1'b0;
   endtask

   task automatic wait_done(input int target, input string name);
      int n = 0;
      while (done_cnt < target && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (done_cnt < target) chk({name, "_timeout"}, 64'(done_cnt), 64'(target));
      @(negedge clk);
      chk({name, "_busy_after"}, 64'(busy), 64'(0));
      chk({name, "_done_after"}, 64'(done), 64'(0));
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d);
      wr_t w;
      w.a = a; w.d = d;
      exp_wr.push_back(w);
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_busy"}, 64'(busy), 64'(0));
      chk({name, "_done"}, 64'(done), 64'(0));
      chk({name, "_req"}, 64'(req), 64'(0));
      chk({name, "_daddr"}, 64'(daddr), 64'(0));
      chk({name, "_valid"}, 64'(valid), 64'(0));
      chk({name, "_paddr"}, 64'(paddr), 64'(0));
      chk({name, "_pdata"}, 64'(pdata), 64'(0));
   endtask

   initial begin
      int r0, v0, d0;
      #2;
      chk_all_zero("reset");
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      // 1: single word, zero wait
      push(32'h8000_0000, 32'hDEADBEEF);
      exp_done.push_back(4);
      start(32'h100, 32'h8000_0000, 16'd1);
      wait_done(1, "t1");

      // 2: four words, dst low bits must be dropped
      push(32'h4000_0000, 32'h0200FDFF);
      push(32'h4000_0004, 32'h0204FDFB);
      push(32'h4000_0008, 32'h0208FDF7);
      push(32'h4000_000C, 32'h020CFDF3);
      exp_done.push_back(13);
      start(32'h200, 32'h4000_0002, 16'd4);
      wait_done(2, "t2");

      // 3: wait states on every handshake: 4 req + 2 wait + 5 wr cycles per word
      gnt_dly = 3; rv_dly = 2; rdy_dly = 4;
      push(32'h6000, 32'h0300FCFF);
      push(32'h6004, 32'h0304FCFB);
      exp_done.push_back(23);
      start(32'h300, 32'h6000, 16'd2);
      wait_done(3, "t3");
      gnt_dly = 0; rv_dly = 1; rdy_dly = 0;

      // 4: zero length
      r0 = req_cnt; v0 = val_cnt;
      exp_done.push_back(1);
      start(32'h700, 32'h7000, 16'd0);
      wait_done(4, "t4");
      chk("t4_no_req", 64'(req_cnt), 64'(r0));
      chk("t4_no_valid", 64'(val_cnt), 64'(v0));

      // 5: address wrap, second strobe mid-transfer is ignored
      push(32'h100, 32'hFFF80007);
      push(32'h104, 32'hFFFC0003);
      push(32'h108, 32'h0000FFFF);
      exp_done.push_back(10);
      start(32'hFFFF_FFF8, 32'h100, 16'd3);
      repeat (3) @(posedge clk);
      #1 dma_en = 1'b1; src = 32'h1000; dst = 32'h5000; len = 16'd5;
      @(posedge clk); #1 dma_en = 1'b0;
      wait_done(5, "t5");

      // 6: reset while stuck in WR, then a fresh transfer
      rdy_dly = 1000;
      d0 = done_cnt;
      start(32'h500, 32'h2000, 16'd2);
      begin
         int n = 0;
         while (!valid && n < 100) begin
            @(negedge clk);
            n++;
         end
         chk("t6_reach_wr", 64'(valid), 64'(1));
      end
      @(posedge clk); #2 rst_n = 1'b0;
      #1 chk_all_zero("t6_rst");
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      rdy_dly = 0;
      chk("t6_no_done", 64'(done_cnt), 64'(d0));
      push(32'h9000, 32'h0400FBFF);
      exp_done.push_back(4);
      start(32'h400, 32'h9000, 16'd1);
      wait_done(d0 + 1, "t6");

      repeat (5) @(negedge clk);
      chk("writes_left", 64'(exp_wr.size()), 64'(0));
      chk("dones_left", 64'(exp_done.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errs, nchk);
      $finish;
   end

endmodule
